// File: rtl/alu_pkg.sv
// Shared ALU definitions: job opcodes, the operand sequencer state encoding
// and the width of the operand-word counters.
package alu_pkg;

  localparam logic [7:0] OP_ADD = 8'h10;
  localparam logic [7:0] OP_MUL = 8'h11;
  localparam logic [7:0] OP_DIV = 8'h12;

  // A 16-bit length minus the 4 header bytes, in 32-bit words, fits in 14 bits.
  localparam int WCNT_W = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_EXEC,
    ST_WAITMUL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/operand_sequencer_if.sv
// Bus bundle for operand_sequencer.
//   start_add_i/start_mul_i/len_i : job start pulses and packet length
//   rx_data_i/rx_valid_i/rx_ready_o : operand byte stream
//   mul_*                         : request/result link to the shared multiplier
//   result_o/done_o               : accumulated result, valid while done_o is high
// slave  : view taken by the sequencer
// master : view taken by whatever drives the sequencer
interface operand_sequencer_if #(
  parameter int datawidth_p = 8
);
  logic                   start_add_i;
  logic                   start_mul_i;
  logic [15:0]            len_i;
  logic [datawidth_p-1:0] rx_data_i;
  logic                   rx_valid_i;
  logic                   rx_ready_o;
  logic [31:0]            mul_a_o;
  logic [31:0]            mul_b_o;
  logic                   mul_valid_o;
  logic                   mul_ready_i;
  logic [31:0]            mul_result_i;
  logic                   mul_result_valid_i;
  logic [31:0]            result_o;
  logic                   done_o;

  modport slave (
    input  start_add_i, start_mul_i, len_i, rx_data_i, rx_valid_i,
           mul_ready_i, mul_result_i, mul_result_valid_i,
    output rx_ready_o, mul_a_o, mul_b_o, mul_valid_o, result_o, done_o
  );

  modport master (
    output start_add_i, start_mul_i, len_i, rx_data_i, rx_valid_i,
           mul_ready_i, mul_result_i, mul_result_valid_i,
    input  rx_ready_o, mul_a_o, mul_b_o, mul_valid_o, result_o, done_o
  );
endinterface

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler.
//   clk_i, rst_i   : clock, async active-high reset
//   clear_i        : drop any partially assembled word
//   byte_i/byte_valid_i : accepted byte strobe
//   word_o/word_valid_o : complete word, valid in the same cycle as its 4th byte
// The 4th byte is passed straight through into the top lane so the caller can
// latch the whole word on the acceptance edge.
module byte_packer #(
  parameter int datawidth_p = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic [datawidth_p-1:0]   byte_i,
  input  logic                     byte_valid_i,
  output logic [4*datawidth_p-1:0] word_o,
  output logic                     word_valid_o
);
  logic [1:0]               cnt_q;
  logic [3*datawidth_p-1:0] low_q;

  assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);
  assign word_o       = {byte_i, low_q};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      low_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
      low_q <= '0;
    end else if (byte_valid_i) begin
      cnt_q <= cnt_q + 2'd1;
      case (cnt_q)
        2'd0:    low_q[0*datawidth_p +: datawidth_p] <= byte_i;
        2'd1:    low_q[1*datawidth_p +: datawidth_p] <= byte_i;
        2'd2:    low_q[2*datawidth_p +: datawidth_p] <= byte_i;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/operand_sequencer.sv
// Operand sequencer: collects a packet of little-endian 32-bit operand words
// from a byte stream and folds them into an accumulator, either by addition
// or through an external multi-cycle multiplier.
//   clk_i : clock, rising edge
//   rst_i : async active-high reset; abandons any job in flight
//   bus   : operand_sequencer_if.slave (start/len, byte stream, multiplier
//           link, result/done)
module operand_sequencer
  import alu_pkg::*;
#(
  parameter int datawidth_p = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  operand_sequencer_if.slave  bus
);
  state_e              state_q, state_d;
  logic [7:0]          opcode_q, opcode_d;
  logic [31:0]         acc_q, acc_d;
  logic [31:0]         word_q, word_d;
  logic [WCNT_W-1:0]   words_total_q, words_total_d;
  logic [WCNT_W-1:0]   words_done_q, words_done_d;
  logic [1:0]          trail_q, trail_d;
  logic                rx_ready_q;

  logic                start, accept, word_phase, pack_valid, pack_clear, finish;
  logic                len_short;
  logic [15:0]         len_rem;
  logic [31:0]         pack_word;
  logic                pack_word_valid;

  assign start      = bus.start_add_i | bus.start_mul_i;
  assign accept     = bus.rx_valid_i && rx_ready_q;
  // Bytes belong to a word until all N words are in; after that they are the
  // discarded tail of the packet.
  assign word_phase = words_done_q < words_total_q;
  assign pack_valid = accept && word_phase;
  assign pack_clear = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // Lengths shorter than the header count as an empty payload.
  assign len_short  = bus.len_i < 16'd4;
  assign len_rem    = len_short ? 16'd0 : (bus.len_i - 16'd4);

  byte_packer #(.datawidth_p(datawidth_p)) u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (pack_clear),
    .byte_i       (bus.rx_data_i),
    .byte_valid_i (pack_valid),
    .word_o       (pack_word),
    .word_valid_o (pack_word_valid)
  );

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    acc_d         = acc_q;
    word_d        = word_q;
    words_total_d = words_total_q;
    words_done_d  = words_done_q;
    trail_d       = trail_q;
    finish        = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          opcode_d      = bus.start_add_i ? OP_ADD : OP_MUL;
          words_total_d = len_rem[15:2];
          trail_d       = len_rem[1:0];
          words_done_d  = '0;
          acc_d         = '0;
          state_d       = (len_rem[15:2] == '0) ? ST_DONE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (pack_valid && pack_word_valid) begin
          word_d  = pack_word;
          state_d = ST_EXEC;
        end else if (accept && !word_phase) begin
          trail_d = trail_q - 2'd1;
          if (trail_q == 2'd1) state_d = ST_DONE;
        end
      end
      ST_EXEC: begin
        // The first word seeds the accumulator regardless of opcode.
        if (words_done_q == '0) begin
          acc_d  = word_q;
          finish = 1'b1;
        end else if (opcode_q == OP_ADD) begin
          acc_d  = acc_q + word_q;
          finish = 1'b1;
        end else if (bus.mul_ready_i) begin
          state_d = ST_WAITMUL;
        end
      end
      ST_WAITMUL: begin
        if (bus.mul_result_valid_i) begin
          acc_d  = bus.mul_result_i;
          finish = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      words_done_d = words_done_q + 1'b1;
      state_d      = ((words_done_d < words_total_q) || (trail_q != 2'd0))
                     ? ST_COLLECT : ST_DONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      opcode_q      <= '0;
      acc_q         <= '0;
      word_q        <= '0;
      words_total_q <= '0;
      words_done_q  <= '0;
      trail_q       <= '0;
      rx_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      acc_q         <= acc_d;
      word_q        <= word_d;
      words_total_q <= words_total_d;
      words_done_q  <= words_done_d;
      trail_q       <= trail_d;
      rx_ready_q    <= (state_d == ST_COLLECT);
    end
  end

  // Multiplier operands come straight from the held registers, so they stay
  // stable for as long as the request is stalled.
  assign bus.rx_ready_o  = rx_ready_q;
  assign bus.mul_a_o     = acc_q;
  assign bus.mul_b_o     = word_q;
  assign bus.mul_valid_o = (state_q == ST_EXEC) && (opcode_q == OP_MUL) &&
                           (words_done_q != '0);
  assign bus.done_o      = (state_q == ST_DONE);
  assign bus.result_o    = acc_q;
endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter datawidth_p, default 8, meaning UART byte width; only 8 is supported.
REQ-002 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start_add_i  input  1  one-cycle pulse that starts an add-accumulate job.
REQ-005 SHALL have port start_mul_i  input  1  one-cycle pulse that starts a multiply-accumulate job.
REQ-006 SHALL have port len_i  input  16  total packet length in bytes, including the 4 header bytes.
REQ-007 SHALL have port rx_data_i  input  datawidth_p  operand byte.
REQ-008 SHALL have port rx_valid_i  input  1  operand byte valid.
REQ-009 SHALL have port rx_ready_o  output  1  operand byte accepted when high together with rx_valid_i.
REQ-010 SHALL have port mul_a_o / mul_b_o  output  32 each  operands to the shared multi-cycle multiplier.
REQ-011 SHALL have port mul_valid_o  output  1  multiplier request.
REQ-012 SHALL have port mul_ready_i  input  1  multiplier accepts the request.
REQ-013 SHALL have port mul_result_i  input  32  low 32 bits of the product.
REQ-014 SHALL have port mul_result_valid_i  input  1  one-cycle product strobe.
REQ-015 SHALL have port result_o  output  32  accumulated result.
REQ-016 SHALL have port done_o  output  1  level; result_o is valid while it is high.

Function
REQ-017 SHALL implement states Idle, Collect, Exec, WaitMul, Done.
REQ-018 SHALL, in Idle or Done on a start pulse, latch the opcode and compute N = (len_i - 4) >> 2 operand words.
  - Opcode latch: add if start_add_i is high, else mul; add wins if both are high.
  - Then clear done_o, the accumulator and the word count, and go to Collect; if N = 0, go to Done instead.
REQ-019 SHALL treat len_i < 4 as N = 0 (no underflow).
REQ-020 SHALL discard the trailing (len_i - 4) mod 4 bytes: accept them in Collect after the last word, then enter Done.
REQ-021 SHALL ignore start pulses in Collect, Exec and WaitMul.
REQ-022 SHALL assert rx_ready_o only in Collect; it is registered.
REQ-023 SHALL accept a byte only on rx_valid_i && rx_ready_o.
REQ-024 SHALL pack each word little-endian: the first byte goes to bits 7:0, the fourth to bits 31:24.
REQ-025 SHALL, on acceptance of the 4th byte of a word, go to Exec with rx_ready_o low the next cycle.
REQ-026 SHALL, in Exec for the first word, load the accumulator with the word (either opcode); this takes 1 cycle.
REQ-027 SHALL, in Exec for add on later words, set acc = acc + word modulo 2^32 (carry dropped); this takes 1 cycle.
REQ-028 SHALL, in Exec for mul on later words, drive mul_a_o = acc, mul_b_o = word and mul_valid_o = 1.
  - Hold these stable until mul_ready_i is high, then go to WaitMul.
REQ-029 SHALL, in WaitMul, set acc = mul_result_i on mul_result_valid_i.
REQ-030 SHALL, after each Exec/WaitMul completion, go to Collect if words remain, or if trailing bytes remain; otherwise go to Done.
REQ-031 SHALL, in Done, hold done_o = 1 and result_o = acc until the next accepted start.
REQ-032 SHALL set result_o = 0 when N = 0.
REQ-033 SHALL ignore mul_result_valid_i outside WaitMul.

Reset
REQ-034 SHALL, on rst_i high asynchronously, set state to Idle and set these outputs to 0:
  - rx_ready_o, mul_valid_o, done_o, result_o, mul_a_o, mul_b_o.
  - Also the internal counters, opcode and accumulator.
REQ-035 SHALL abandon any job on reset mid-operation; the multiplier request is dropped with no handshake completion.

Structure
REQ-036 SHALL take opcode constants (ADD 8'h10, MUL 8'h11, DIV 8'h12) and the state enum from shared package alu_pkg.
REQ-037 SHALL place byte-to-word assembly in sub-module byte_packer (byte in, 32-bit word plus word_valid out, clear input).

Verification
REQ-038 SHALL cover: start_add, len 12, bytes 01 00 00 00 02 00 00 00 -> done_o = 1, result_o = 0x00000003.
REQ-039 SHALL cover: start_mul, len 16, words 3, 5, 7; multiplier with 4-cycle latency and mul_ready_i stalled 2 cycles -> result_o = 0x00000069; mul_valid_o stable during the stall.
REQ-040 SHALL cover: start_add, len 13, words 0xFFFFFFFF and 0x00000002 plus 1 trailing byte -> result_o = 0x00000001; the trailing byte is accepted.
REQ-041 SHALL cover: start_add with len 3 -> no rx_ready_o, done_o = 1 after 1 cycle, result_o = 0.
REQ-042 SHALL cover: start_add and start_mul in the same cycle, len 8, word 9 -> add job, result 9; a start pulse during Collect is ignored.
REQ-043 SHALL cover: rst_i pulsed during WaitMul -> all outputs 0, Idle; a new job afterwards completes correctly.
